shift_arb_8: RTL
================

SHIFT_ARB_8 -- requirements
Module: shift_arb_8

Interface
REQ-001 Clock and reset: one clock, reset asynchronous and active-high.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous active-high reset.
REQ-004 req0_valid  input  1  requester 0 has an operation pending.
REQ-005 req0_a  input  8  requester 0 operand.
REQ-006 req0_b  input  8  requester 0 shift amount; only [2:0] used.
REQ-007 req0_ready  output  1  requester 0 operation accepted this cycle.
REQ-008 req1_valid, req1_a, req1_b, req1_ready: same as requester 0, for requester 1.
REQ-009 res_valid  output  1  result register holds an unconsumed result.
REQ-010 res_s  output  8  result, a shifted left logically by b[2:0], zero-filled.
REQ-011 res_id  output  1  requester that owns res_s (0 or 1).
REQ-012 res_ready  input  1  consumer takes the result this cycle.

Function
REQ-013 States: IDLE (result register empty) and HOLD (result register full).
REQ-014 Transfer: an operation is accepted when reqN_valid and reqN_ready are both high on a rising edge; a result is consumed when res_valid and res_ready are both high.
REQ-015 Slot free: "slot free" is true in IDLE, or in HOLD with res_ready high.
REQ-016 Ready: reqN_ready is combinational and is high only for the granted requester while slot free; at most one ready is high per cycle.
REQ-017 Grant: if exactly one reqN_valid is high, that requester is granted.
REQ-018 Contention: if both are valid, grant follows REQ-028/REQ-029.
REQ-019 Accept: on accept, the next edge loads res_s from the granted operands and res_id with the granted index, sets res_valid, and enters HOLD; latency is 1 cycle.
REQ-020 Shift arithmetic: res_s = a << b[2:0]; b[7:3] are ignored; shift 0 passes a unchanged; shift 7 yields {a[0],7'b0}.
REQ-021 HOLD with res_ready low: res_valid, res_s, and res_id hold stable, and both reqN_ready are low.
REQ-022 HOLD with res_ready high and a request valid: consume and accept in the same edge, giving one result per cycle when back-to-back.
REQ-023 HOLD with res_ready high and no request: return to IDLE and clear res_valid.
REQ-024 IDLE: res_ready is ignored and res_valid stays low.
REQ-025 Requesters may change operands or drop valid at any time before acceptance; no request is latched before acceptance.

Reset
REQ-026 Reset state: on rst, the FSM goes to IDLE, res_valid=0, res_s=8'h00, res_id=0, and the round-robin pointer favours requester 0.
REQ-027 Reset mid-operation: a reset in HOLD discards the held result with no consume indication; no request is accepted while rst is high, so both reqN_ready are low.

Configuration
REQ-028 With SHIFT_ARB_RR_EN defined: contention uses round-robin. The requester not granted on the most recent accept wins. The pointer updates only on accept.
REQ-029 With SHIFT_ARB_RR_EN undefined: fixed priority, so requester 0 always wins contention. The pointer logic is absent.

Verification
REQ-030 Single shift: req0 a=8'hB5, b=8'h03, consumer ready -> next cycle res_valid=1, res_s=8'hA8, res_id=0.
REQ-031 Ignored bits: req1 a=8'h81, b=8'hFF (eff. 7) -> res_s=8'h80, res_id=1; b=8'hF8 (eff. 0) -> res_s=8'h81.
REQ-032 Backpressure: hold res_ready=0 for 4 cycles after a result -> res_s/res_id stable, req0_ready=req1_ready=0 throughout; release -> consumed, IDLE next cycle.
REQ-033 Contention: both valid continuously with res_ready=1 for 4 accepts.
  - With SHIFT_ARB_RR_EN defined: res_id sequence 0,1,0,1.
  - Without it: res_id sequence 0,0,0,0.
REQ-034 Throughput: 8 back-to-back req0 ops, b=0..7, a=8'hFF, res_ready=1 -> results FF,FE,FC,F8,F0,E0,C0,80 on consecutive cycles.
REQ-035 Reset in HOLD: assert rst asynchronously while res_valid=1 -> res_valid=0, res_s=8'h00 immediately; the first accept after release follows reset priority.

Source files
------------

// File: rtl/shift_arb_8.sv
// rtl/shift_arb_8.sv - two-requester arbiter feeding an 8-bit left-shift result register
// Optional round-robin contention policy: define SHIFT_ARB_RR_EN (default build is fixed priority, requester 0 wins).

module shift_arb_8 (
   input  logic       clk,
   input  logic       rst,
   input  logic       req0_valid,
   input  logic [7:0] req0_a,
   input  logic [7:0] req0_b,
   output logic       req0_ready,
   input  logic       req1_valid,
   input  logic [7:0] req1_a,
   input  logic [7:0] req1_b,
   output logic       req1_ready,
   output logic       res_valid,
   output logic [7:0] res_s,
   output logic       res_id,
   input  logic       res_ready
);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_HOLD = 1'b1;

   logic [0:0] state_q, state_d;
   logic [7:0] res_s_q, res_s_d;
   logic       res_id_q, res_id_d;

   logic       slot_free;
   logic       grant;
   logic       accept;
   logic [7:0] sel_a;
   logic [2:0] sel_sh;
   logic       unused_b_bits;

`ifdef SHIFT_ARB_RR_EN
   logic rr_q, rr_d;
`endif

   // Only the low three bits of each shift amount matter.
   assign unused_b_bits = ^{req0_b[7:3], req1_b[7:3]};

   always_comb begin
      grant = 1'b0;
      if (req1_valid && !req0_valid) begin
         grant = 1'b1;
      end else if (req0_valid && req1_valid) begin
`ifdef SHIFT_ARB_RR_EN
         grant = rr_q;
`else
         grant = 1'b0;
`endif
      end
   end

   // Readies are gated by rst so nothing is accepted while reset is held.
   assign slot_free  = (state_q == ST_IDLE) || res_ready;
   assign accept     = !rst && slot_free && (req0_valid || req1_valid);
   assign req0_ready = accept && !grant;
   assign req1_ready = accept && grant;

   assign sel_a  = grant ? req1_a      : req0_a;
   assign sel_sh = grant ? req1_b[2:0] : req0_b[2:0];

   always_comb begin
      state_d  = state_q;
      res_s_d  = res_s_q;
      res_id_d = res_id_q;
      if (accept) begin
         state_d  = ST_HOLD;
         res_s_d  = sel_a << sel_sh;
         res_id_d = grant;
      end else if ((state_q == ST_HOLD) && res_ready) begin
         state_d = ST_IDLE;
      end
   end

`ifdef SHIFT_ARB_RR_EN
   // Pointer names the requester that wins the next contention.
   always_comb begin
      rr_d = rr_q;
      if (accept) begin
         rr_d = ~grant;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_q <= 1'b0;
      end else begin
         rr_q <= rr_d;
      end
   end
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         res_s_q  <= 8'h00;
         res_id_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         res_s_q  <= res_s_d;
         res_id_q <= res_id_d;
      end
   end

   assign res_valid = (state_q == ST_HOLD);
   assign res_s     = res_s_q;
   assign res_id    = res_id_q;

endmodule
